// File: rtl/rx_xgmii.sv
// -----------------------------------------------------------------------------
// rx_xgmii : 64-bit XGMII receive framer (10G).
//
// Finds the start word, checks preamble/SFD and delivers DA..FCS as 64-bit
// words with sop/eop/byte-valid markers. Flags framing, runt and oversize
// errors and keeps good-packet, good-byte and error counters.
//
// Ports
//   clk156           in   core clock
//   rst_             in   asynchronous active-low reset
//   rxd[63:0]        in   XGMII data, lane 0 = [7:0]
//   rxc[7:0]         in   XGMII control, bit i -> lane i
//   fmac_rx_clr_en   in   synchronous clear of all three counters
//   out_data[63:0]   out  payload word, first byte in [7:0]; holds when idle
//   out_valid        out  out_data valid this cycle (single-cycle pulse)
//   out_sop          out  first word of frame
//   out_eop          out  last word of frame
//   out_bytes[3:0]   out  valid low lanes: 8 unless eop, 1..8 on eop
//   out_err          out  frame bad, valid with eop only
//   out_len[15:0]    out  frame byte count DA..FCS, valid with eop, saturating
//   FMAC_RX_PKT_CNT  out  good frames received
//   FMAC_RX_BYTE_CNT out  sum of out_len of good frames
//   FMAC_RX_ERR_CNT  out  bad frames (eop err, preamble reject, abort)
//   dbg_state[1:0]   out  framer FSM state (0 idle, 1 data, 2 drop)
//
// Handshake: there is no backpressure. Every cycle with out_valid=1 carries a
// word that the consumer must take; out_sop/out_eop/out_err only mean
// something while out_valid=1.
//
// Latency: a word sampled on rxd sits in a one-word hold register and is
// emitted when the following word is decoded, so out_valid appears two
// clocks after the word was on rxd.
// -----------------------------------------------------------------------------
module rx_xgmii #(
    parameter int MIN_BYTES = 64,
    parameter int MAX_BYTES = 1518
) (
    input  logic        clk156,
    input  logic        rst_,
    input  logic [63:0] rxd,
    input  logic [7:0]  rxc,
    input  logic        fmac_rx_clr_en,
    output logic [63:0] out_data,
    output logic        out_valid,
    output logic        out_sop,
    output logic        out_eop,
    output logic [3:0]  out_bytes,
    output logic        out_err,
    output logic [15:0] out_len,
    output logic [31:0] FMAC_RX_PKT_CNT,
    output logic [31:0] FMAC_RX_BYTE_CNT,
    output logic [31:0] FMAC_RX_ERR_CNT,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam logic [63:0] SOF_WORD = 64'hD5555555555555FB;
    localparam logic [15:0] MIN_L    = MIN_BYTES[15:0];
    localparam logic [15:0] MAX_L    = MAX_BYTES[15:0];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state, state_n;
    logic [63:0] hold_data, hold_data_n;
    logic        hold_full, hold_full_n;
    logic        pending, pending_n;     // hold carries a partial last word
    logic [3:0]  pend_bytes, pend_bytes_n;
    logic        first, first_n;         // no word of this frame emitted yet
    logic [15:0] frame_len, len_n;       // bytes loaded into hold so far
    logic        err_pulse;              // frame rejected without an eop

    // ------------------------------------------------------------------
    // Word decode
    // ------------------------------------------------------------------
    logic       start_lane0;
    logic       is_start;
    logic       term_valid;
    logic [2:0] term_k;
    logic       term_found;

    always_comb begin
        start_lane0 = rxc[0] && (rxd[7:0] == 8'hFB);
        is_start    = (rxc == 8'h01) && (rxd == SOF_WORD);
        term_found  = 1'b0;
        term_k      = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!term_found && rxc[i]) begin
                term_found = 1'b1;
                term_k     = i[2:0];
            end
        end
        // Lowest control lane must be FD, everything above it control,
        // everything below it data.
        term_valid = term_found
                  && (rxd[{term_k, 3'b000} +: 8] == 8'hFD)
                  && (rxc == (8'hFF << term_k));
    end

    function automatic logic [15:0] sat_add(input logic [15:0] a,
                                            input logic [3:0]  b);
        logic [16:0] s;
        s = {1'b0, a} + {13'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // ------------------------------------------------------------------
    // Next state / emission
    // ------------------------------------------------------------------
    logic       emit;
    logic       e_eop;
    logic [3:0] e_bytes;
    logic       e_abort;
    logic       e_err;
    logic       direct_err;

    always_comb begin
        state_n      = state;
        hold_data_n  = hold_data;
        hold_full_n  = hold_full;
        pending_n    = 1'b0;
        pend_bytes_n = pend_bytes;
        first_n      = first;
        len_n        = frame_len;
        emit         = 1'b0;
        e_eop        = 1'b0;
        e_bytes      = 4'd8;
        e_abort      = 1'b0;
        direct_err   = 1'b0;

        // The partial last word goes out on the cycle after the terminate,
        // whatever is decoded now (a back-to-back start included). The FSM
        // is already in IDLE here, so only the IDLE branch below can run.
        if (pending) begin
            emit        = 1'b1;
            e_eop       = 1'b1;
            e_bytes     = pend_bytes;
            hold_full_n = 1'b0;
            first_n     = 1'b0;
        end

        case (state)
            IDLE: begin
                if (is_start) begin
                    state_n     = DATA;
                    first_n     = 1'b1;
                    len_n       = 16'd0;
                    hold_full_n = 1'b0;
                end else if (start_lane0) begin
                    state_n    = DROP;
                    direct_err = 1'b1;
                end
            end

            DATA: begin
                if (rxc == 8'h00) begin
                    if (hold_full) begin
                        emit    = 1'b1;
                        first_n = 1'b0;
                    end
                    hold_data_n = rxd;
                    hold_full_n = 1'b1;
                    len_n       = sat_add(frame_len, 4'd8);
                end else if (is_start) begin
                    // New frame aborts the current one and opens at once.
                    if (hold_full) begin
                        emit    = 1'b1;
                        e_eop   = 1'b1;
                        e_abort = 1'b1;
                    end else begin
                        direct_err = 1'b1;
                    end
                    hold_full_n = 1'b0;
                    first_n     = 1'b1;
                    len_n       = 16'd0;
                end else if (term_valid) begin
                    state_n = IDLE;
                    if (term_k == 3'd0) begin
                        if (hold_full) begin
                            emit  = 1'b1;
                            e_eop = 1'b1;
                        end else begin
                            // start immediately followed by terminate
                            direct_err = 1'b1;
                        end
                        hold_full_n = 1'b0;
                        first_n     = 1'b0;
                    end else begin
                        if (hold_full) begin
                            emit    = 1'b1;
                            first_n = 1'b0;
                        end
                        hold_data_n  = rxd;
                        hold_full_n  = 1'b1;
                        pending_n    = 1'b1;
                        pend_bytes_n = {1'b0, term_k};
                        len_n        = sat_add(frame_len, {1'b0, term_k});
                    end
                end else begin
                    // Any other control content is a framing error.
                    state_n = DROP;
                    if (hold_full) begin
                        emit    = 1'b1;
                        e_eop   = 1'b1;
                        e_abort = 1'b1;
                    end else begin
                        direct_err = 1'b1;
                    end
                    hold_full_n = 1'b0;
                    first_n     = 1'b0;
                end
            end

            DROP: begin
                if (rxc == 8'hFF) state_n = IDLE;
            end

            default: state_n = IDLE;
        endcase

        e_err = e_abort || (frame_len < MIN_L) || (frame_len > MAX_L);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk156 or negedge rst_) begin
        if (!rst_) begin
            state      <= IDLE;
            hold_data  <= 64'd0;
            hold_full  <= 1'b0;
            pending    <= 1'b0;
            pend_bytes <= 4'd0;
            first      <= 1'b0;
            frame_len  <= 16'd0;
            err_pulse  <= 1'b0;
            out_data   <= 64'd0;
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_bytes  <= 4'd0;
            out_err    <= 1'b0;
            out_len    <= 16'd0;
        end else begin
            state      <= state_n;
            hold_data  <= hold_data_n;
            hold_full  <= hold_full_n;
            pending    <= pending_n;
            pend_bytes <= pend_bytes_n;
            first      <= first_n;
            frame_len  <= len_n;
            err_pulse  <= direct_err;
            out_valid  <= emit;
            out_sop    <= emit && first;
            out_eop    <= emit && e_eop;
            out_bytes  <= emit ? e_bytes : 4'd0;
            out_err    <= emit && e_eop && e_err;
            out_len    <= (emit && e_eop) ? frame_len : 16'd0;
            if (emit) out_data <= hold_data;
        end
    end

    // ------------------------------------------------------------------
    // Counters: updated the cycle after the eop appears on the outputs.
    // ------------------------------------------------------------------
    logic good_eop, bad_eop;
    assign good_eop = out_valid && out_eop && !out_err;
    assign bad_eop  = out_valid && out_eop && out_err;

    always_ff @(posedge clk156 or negedge rst_) begin
        if (!rst_) begin
            FMAC_RX_PKT_CNT  <= 32'd0;
            FMAC_RX_BYTE_CNT <= 32'd0;
            FMAC_RX_ERR_CNT  <= 32'd0;
        end else if (fmac_rx_clr_en) begin
            FMAC_RX_PKT_CNT  <= 32'd0;
            FMAC_RX_BYTE_CNT <= 32'd0;
            FMAC_RX_ERR_CNT  <= 32'd0;
        end else begin
            if (good_eop) begin
                FMAC_RX_PKT_CNT  <= FMAC_RX_PKT_CNT + 32'd1;
                FMAC_RX_BYTE_CNT <= FMAC_RX_BYTE_CNT + {16'd0, out_len};
            end
            FMAC_RX_ERR_CNT <= FMAC_RX_ERR_CNT + {31'd0, bad_eop}
                                               + {31'd0, err_pulse};
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_rx_xgmii.sv
// -----------------------------------------------------------------------------
// tb_rx_xgmii : self-checking bench for rx_xgmii.
// Frames are described in a table of {payload words, terminate lane,
// expected length, expected error}; a few hand-written sequences cover
// framing errors, aborts, back-to-back frames, reset and counter clear.
// -----------------------------------------------------------------------------
module tb_rx_xgmii;

    localparam logic [63:0] SOF    = 64'hD5555555555555FB;
    localparam logic [63:0] IDLE_W = 64'h0707070707070707;

    logic        clk156 = 1'b0;
    logic        rst_;
    logic [63:0] rxd;
    logic [7:0]  rxc;
    logic        fmac_rx_clr_en;
    logic [63:0] out_data;
    logic        out_valid, out_sop, out_eop, out_err;
    logic [3:0]  out_bytes;
    logic [15:0] out_len;
    logic [31:0] pkt_cnt, byte_cnt, err_cnt;
    logic [1:0]  dbg_state;

    rx_xgmii #(.MIN_BYTES(64), .MAX_BYTES(1518)) dut (
        .clk156           (clk156),
        .rst_             (rst_),
        .rxd              (rxd),
        .rxc              (rxc),
        .fmac_rx_clr_en   (fmac_rx_clr_en),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_sop          (out_sop),
        .out_eop          (out_eop),
        .out_bytes        (out_bytes),
        .out_err          (out_err),
        .out_len          (out_len),
        .FMAC_RX_PKT_CNT  (pkt_cnt),
        .FMAC_RX_BYTE_CNT (byte_cnt),
        .FMAC_RX_ERR_CNT  (err_cnt),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock ----------------
    always #3 clk156 = ~clk156;

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    // expected word: {data, sop, eop, bytes, err, len}
    localparam int EW = 64 + 1 + 1 + 4 + 1 + 16;
    logic [EW-1:0] exp_q[$];

    logic [31:0] exp_pkt  = 0;
    logic [31:0] exp_byte = 0;
    logic [31:0] exp_err  = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] d, input bit sop, input bit eop,
                        input int bytes, input bit err, input int len);
        logic [3:0]  b;
        logic [15:0] l;
        b = bytes[3:0];
        l = len[15:0];
        exp_q.push_back({d, sop, eop, b, err, l});
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk156) begin
        if (rst_ && out_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_word: got data %h, no word expected", out_data);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("word_data", out_data, e[86:23]);
                check("word_sop", {63'd0, out_sop}, {63'd0, e[22]});
                check("word_eop", {63'd0, out_eop}, {63'd0, e[21]});
                check("word_bytes", {60'd0, out_bytes}, {60'd0, e[20:17]});
                if (e[21]) begin
                    check("eop_err", {63'd0, out_err}, {63'd0, e[16]});
                    check("eop_len", {48'd0, out_len}, {48'd0, e[15:0]});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_word(input logic [63:0] d, input logic [7:0] c);
        @(posedge clk156);
        #1;
        rxd = d;
        rxc = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_word(IDLE_W, 8'hFF);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] term_word(input int k);
        logic [63:0] w;
        w = rnd64();
        for (int i = 0; i < 8; i++) begin
            if (i == k)     w[8*i +: 8] = 8'hFD;
            else if (i > k) w[8*i +: 8] = 8'h07;
        end
        return w;
    endfunction

    // start, n payload words, terminate in lane k; leaves the terminate
    // word on the bus so back-to-back frames can follow directly.
    task automatic send_frame(input int n, input int k, input int elen,
                              input bit eerr);
        logic [63:0] d;
        logic [7:0]  c;
        send_word(SOF, 8'h01);
        for (int i = 0; i < n; i++) begin
            d = rnd64();
            send_word(d, 8'h00);
            if (k == 0 && i == n - 1) push(d, i == 0, 1'b1, 8, eerr, elen);
            else                      push(d, i == 0, 1'b0, 8, 1'b0, 0);
        end
        d = term_word(k);
        c = 8'hFF;
        c = c << k;
        send_word(d, c);
        if (k > 0) push(d, n == 0, 1'b1, k, eerr, elen);
        if (eerr) exp_err++;
        else begin
            exp_pkt++;
            exp_byte += elen[31:0];
        end
    endtask

    task automatic check_cnt(input string tag);
        @(negedge clk156);
        check({tag, "_pkt_cnt"}, {32'd0, pkt_cnt}, {32'd0, exp_pkt});
        check({tag, "_byte_cnt"}, {32'd0, byte_cnt}, {32'd0, exp_byte});
        check({tag, "_err_cnt"}, {32'd0, err_cnt}, {32'd0, exp_err});
    endtask

    // ---------------- frame table ----------------
    typedef struct {
        int n;      // payload words
        int k;      // terminate lane
        int len;    // expected out_len
        bit err;    // expected out_err
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [63:0] d1, d2, d3, d4;
        bit          seen;

        vecs[0] = '{8,   0, 64,   1'b0};
        vecs[1] = '{8,   3, 67,   1'b0};
        vecs[2] = '{2,   0, 16,   1'b1};
        vecs[3] = '{190, 0, 1520, 1'b1};
        vecs[4] = '{7,   7, 63,   1'b1};
        vecs[5] = '{189, 6, 1518, 1'b0};
        vecs[6] = '{189, 7, 1519, 1'b1};
        vecs[7] = '{0,   5, 5,    1'b1};
        vecs[8] = '{0,   0, 0,    1'b1};
        vecs[9] = '{12,  1, 97,   1'b0};

        // ---------------- reset ----------------
        rst_           = 1'b0;
        rxd            = IDLE_W;
        rxc            = 8'hFF;
        fmac_rx_clr_en = 1'b0;
        repeat (3) @(posedge clk156);
        #1 rst_ = 1'b1;
        @(negedge clk156);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_eop", {63'd0, out_eop}, 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_len", {48'd0, out_len}, 64'd0);
        check("rst_state", {62'd0, dbg_state}, 64'd0);
        check_cnt("rst");

        // ---------------- table frames ----------------
        for (int v = 0; v < 10; v++) begin
            send_frame(vecs[v].n, vecs[v].k, vecs[v].len, vecs[v].err);
            idle(4);
            check_cnt($sformatf("vec%0d", v));
        end

        // ---------------- error word mid-frame, DROP, recovery ----------------
        d1 = rnd64(); d2 = rnd64(); d3 = rnd64(); d4 = rnd64();
        send_word(SOF, 8'h01);
        send_word(d1, 8'h00); push(d1, 1'b1, 1'b0, 8, 1'b0, 0);
        send_word(d2, 8'h00); push(d2, 1'b0, 1'b0, 8, 1'b0, 0);
        send_word(d3, 8'h00); push(d3, 1'b0, 1'b0, 8, 1'b0, 0);
        send_word(d4, 8'h00); push(d4, 1'b0, 1'b1, 8, 1'b1, 32);
        d1 = rnd64();
        d1[23:16] = 8'hFE;
        send_word(d1, 8'h04);
        exp_err++;
        send_word(rnd64(), 8'h00);      // ignored while dropping
        send_word(SOF, 8'h01);          // not a frame start in DROP
        send_word(rnd64(), 8'h00);
        idle(2);
        check("drop_exit_state", {62'd0, dbg_state}, 64'd0);
        send_frame(8, 0, 64, 1'b0);
        idle(4);
        check_cnt("errword");

        // ---------------- back-to-back frames ----------------
        send_frame(8, 4, 68, 1'b0);
        send_frame(8, 0, 64, 1'b0);
        idle(4);
        check_cnt("b2b");

        // ---------------- start word inside a frame aborts it ----------------
        d1 = rnd64(); d2 = rnd64(); d3 = rnd64();
        send_word(SOF, 8'h01);
        send_word(d1, 8'h00); push(d1, 1'b1, 1'b0, 8, 1'b0, 0);
        send_word(d2, 8'h00); push(d2, 1'b0, 1'b0, 8, 1'b0, 0);
        send_word(d3, 8'h00); push(d3, 1'b0, 1'b1, 8, 1'b1, 24);
        exp_err++;
        send_frame(8, 0, 64, 1'b0);
        idle(4);
        check_cnt("abort");

        // ---------------- bad SFD ----------------
        send_word(64'h55555555555555FB, 8'h01);
        exp_err++;
        for (int i = 0; i < 3; i++) send_word(rnd64(), 8'h00);
        idle(4);
        check_cnt("bad_sfd");

        // ---------------- counter clear coincident with a good eop ----------------
        send_frame(8, 0, 64, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk156);
            if (out_valid && out_eop) seen = 1'b1;
        end
        check("clr_eop_seen", {63'd0, seen}, 64'd1);
        fmac_rx_clr_en = 1'b1;          // overlaps the counter update edge
        @(posedge clk156);
        #1 fmac_rx_clr_en = 1'b0;
        exp_pkt  = 0;
        exp_byte = 0;
        exp_err  = 0;
        idle(2);
        check_cnt("clr");
        send_frame(8, 2, 66, 1'b0);
        idle(4);
        check_cnt("after_clr");

        // ---------------- reset in the middle of a frame ----------------
        send_word(SOF, 8'h01);
        for (int i = 0; i < 5; i++) begin
            d1 = rnd64();
            send_word(d1, 8'h00);
            if (i < 4) push(d1, i == 0, 1'b0, 8, 1'b0, 0);
        end
        @(posedge clk156);
        @(negedge clk156);
        #1 rst_ = 1'b0;
        #1;
        check("midrst_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_eop", {63'd0, out_eop}, 64'd0);
        check("midrst_data", out_data, 64'd0);
        check("midrst_pkt_cnt", {32'd0, pkt_cnt}, 64'd0);
        check("midrst_q_left", {32'd0, exp_q.size()}, 64'd0);
        exp_q.delete();
        exp_pkt  = 0;
        exp_byte = 0;
        exp_err  = 0;
        rxd = IDLE_W;
        rxc = 8'hFF;
        repeat (2) @(posedge clk156);
        #1 rst_ = 1'b1;
        idle(4);
        check_cnt("post_rst");
        send_frame(9, 0, 72, 1'b0);
        idle(4);
        check_cnt("final");

        // ---------------- drain ----------------
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk156);
        check("queue_drained", {32'd0, exp_q.size()}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
